// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM state type and op-class helper for the sequential ALU.
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD = 6'h0A;
    localparam logic [5:0] OP_SUB = 6'h0B;
    localparam logic [5:0] OP_LSR = 6'h0C;
    localparam logic [5:0] OP_LSL = 6'h0D;
    localparam logic [5:0] OP_RSR = 6'h0E;
    localparam logic [5:0] OP_RSL = 6'h0F;
    localparam logic [5:0] OP_MOV = 6'h10;
    localparam logic [5:0] OP_MUL = 6'h11;
    localparam logic [5:0] OP_DIV = 6'h12;
    localparam logic [5:0] OP_MOD = 6'h13;
    localparam logic [5:0] OP_AND = 6'h14;
    localparam logic [5:0] OP_OR  = 6'h15;
    localparam logic [5:0] OP_XOR = 6'h16;
    localparam logic [5:0] OP_NOT = 6'h17;
    localparam logic [5:0] OP_CMP = 6'h18;
    localparam logic [5:0] OP_TST = 6'h19;
    localparam logic [5:0] OP_INC = 6'h1A;
    localparam logic [5:0] OP_DEC = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    function automatic logic is_iter(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready request and response bundle between the decode stage and the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             c;
    logic             o;
    logic             err;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, z, n, c, o, err
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, z, n, c, o, err
    );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: unsigned shift-add multiply and restoring divide, one bit per cycle.
module alu_seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_isMul,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int SHW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_isMul;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divTrial;
    logic [WIDTH-1:0] w_divDiff;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_qNext;

    assign w_mulSum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_divTrial = {r_acc, r_q[WIDTH-1]};
    assign w_divDiff  = w_divTrial[WIDTH-1:0] - r_b;

    // A zero divisor always subtracts, leaving quotient all-ones and remainder = dividend.
    always_comb begin
        if (r_isMul) begin
            w_accNext = w_mulSum[WIDTH:1];
            w_qNext   = {w_mulSum[0], r_q[WIDTH-1:1]};
        end else if (w_divTrial >= {1'b0, r_b}) begin
            w_accNext = w_divDiff;
            w_qNext   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_accNext = w_divTrial[WIDTH-1:0];
            w_qNext   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));
    assign o_lo   = w_qNext;
    assign o_hi   = w_accNext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_isMul <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_isMul <= i_isMul;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= i_a;
            r_b     <= i_b;
        end else if (r_busy) begin
            r_acc <= w_accNext;
            r_q   <= w_qNext;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle ops, iterative MUL/DIV/MOD, valid/ready on both sides.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic             r_inReady;
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_o;
    logic             r_err;
    logic [5:0]       r_op;
    logic             r_divZero;

    logic             w_accept;
    logic             w_start;
    logic             w_done;
    logic             w_c;
    logic             w_o;
    logic             w_err;
    logic             w_flagsOn;
    logic [WIDTH-1:0] w_opB;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_rotL;
    logic [WIDTH-1:0] w_rotR;
    logic [WIDTH-1:0] w_iterRes;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_rotAmt;

    assign w_accept = bus.in_valid && r_inReady;
    assign w_start  = w_accept && is_iter(bus.opcode);

    assign w_opB = ((bus.opcode == OP_INC) || (bus.opcode == OP_DEC))
                   ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.b;
    assign w_add = {1'b0, bus.a} + {1'b0, w_opB};
    assign w_sub = {1'b0, bus.a} - {1'b0, w_opB};

    // The extra guard bit catches the last bit shifted out; full-width b makes large amounts give 0.
    assign w_shl    = {1'b0, bus.a} << bus.b;
    assign w_shr    = {bus.a, 1'b0} >> bus.b;
    assign w_rotAmt = bus.b[SHW-1:0];
    assign w_rotL   = (bus.a << w_rotAmt) | (bus.a >> (WIDTH - int'(w_rotAmt)));
    assign w_rotR   = (bus.a >> w_rotAmt) | (bus.a << (WIDTH - int'(w_rotAmt)));

    always_comb begin
        w_res     = '0;
        w_c       = 1'b0;
        w_o       = 1'b0;
        w_err     = 1'b0;
        w_flagsOn = 1'b1;
        case (bus.opcode)
            OP_ADD, OP_INC: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_o   = (bus.a[WIDTH-1] == w_opB[WIDTH-1]) && (w_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_CMP, OP_DEC: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_o   = (bus.a[WIDTH-1] != w_opB[WIDTH-1]) && (w_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_LSL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_LSR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_RSL:         w_res = w_rotL;
            OP_RSR:         w_res = w_rotR;
            OP_MOV: begin
                w_res     = bus.b;
                w_flagsOn = 1'b0;
            end
            OP_AND, OP_TST: w_res = bus.a & bus.b;
            OP_OR:          w_res = bus.a | bus.b;
            OP_XOR:         w_res = bus.a ^ bus.b;
            OP_NOT:         w_res = ~bus.a;
            OP_MUL, OP_DIV, OP_MOD: begin
            end
            default: begin
                w_err     = 1'b1;
                w_flagsOn = 1'b0;
            end
        endcase
    end

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_isMul (bus.opcode == OP_MUL),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_done  (w_done),
        .o_lo    (w_lo),
        .o_hi    (w_hi)
    );

    assign w_iterRes = (r_op == OP_MOD) ? w_hi : w_lo;

    // Outputs are only rewritten on a completion edge, so they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_o        <= 1'b0;
            r_err      <= 1'b0;
            r_op       <= '0;
            r_divZero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inReady <= 1'b1;
                    if (w_accept) begin
                        r_inReady <= 1'b0;
                        r_op      <= bus.opcode;
                        r_divZero <= (bus.b == '0);
                        if (is_iter(bus.opcode)) begin
                            r_state <= ITER;
                        end else begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                            r_result   <= w_res;
                            r_z        <= w_flagsOn && (w_res == '0);
                            r_n        <= w_flagsOn && w_res[WIDTH-1];
                            r_c        <= w_c;
                            r_o        <= w_o;
                            r_err      <= w_err;
                        end
                    end
                end
                ITER: begin
                    if (w_done) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_result   <= w_iterRes;
                        r_z        <= (w_iterRes == '0);
                        r_n        <= w_iterRes[WIDTH-1];
                        r_c        <= 1'b0;
                        r_o        <= (r_op == OP_MUL) && (w_hi != '0);
                        r_err      <= r_divZero && (r_op != OP_MUL);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.c         = r_c;
    assign bus.o         = r_o;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors queue expectations, a negedge monitor checks responses.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [15:0] result;
        logic [4:0]  flags;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    exp_t expQ[$];

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reportTimeout(input string nm);
        tests++;
        failed++;
        $display("[TB] FAIL %s: wait bound expired", nm);
    endtask

    // Flags are compared as one vector {z,n,c,o,err}.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpectedOutput: got result %h with empty scoreboard", bus.result);
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_result"}, {16'h0, bus.result}, {16'h0, e.result});
                checkOutput({e.name, "_flags"}, {27'h0, bus.z, bus.n, bus.c, bus.o, bus.err},
                            {27'h0, e.flags});
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [15:0] ta, input logic [15:0] tbv,
                                 input logic [15:0] er, input logic [4:0] ef, input string nm,
                                 input bit push);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!bus.in_ready) begin
            reportTimeout({nm, "_inReady"});
            return;
        end
        bus.opcode   = op;
        bus.a        = ta;
        bus.b        = tbv;
        bus.in_valid = 1'b1;
        if (push) expQ.push_back('{er, ef, nm});
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string nm);
        int guard = 0;
        while ((expQ.size() != 0 || !bus.in_ready) && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (expQ.size() != 0 || !bus.in_ready) reportTimeout({nm, "_drain"});
    endtask

    task automatic measureLatency(output int lat, output bit readySeen);
        lat       = 0;
        readySeen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) readySeen = 1'b1;
            @(posedge clk);
            #2;
            lat++;
        end
        if (!bus.out_valid) reportTimeout("latency");
    endtask

    task automatic runOp(input logic [5:0] op, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [15:0] er, input logic [4:0] ef, input string nm);
        applyStimulus(op, ta, tbv, er, ef, nm, 1'b1);
        waitIdle(nm);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bit rdySeen;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstOutValid", bus.out_valid, 0);
        checkOutput("rstInReady", bus.in_ready, 0);
        checkOutput("rstResult", bus.result, 0);
        checkOutput("rstFlags", {bus.z, bus.n, bus.c, bus.o, bus.err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("rstReleaseInReady", bus.in_ready, 1);

        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100, "addCarry", 1'b1);
        measureLatency(lat, rdySeen);
        checkOutput("addLatency", lat, 0);
        waitIdle("addCarry");

        runOp(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, "addOvf");
        runOp(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100, "subBorrow");
        runOp(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, "subOvf");
        runOp(OP_CMP, 16'h0005, 16'h0005, 16'h0000, 5'b10000, "cmpEqual");
        runOp(OP_INC, 16'h7FFF, 16'h1234, 16'h8000, 5'b01010, "incOvf");
        runOp(OP_DEC, 16'h0000, 16'h1234, 16'hFFFF, 5'b01100, "decBorrow");
        runOp(OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 5'b00010, "decOvf");
        runOp(OP_LSL, 16'h8001, 16'h0001, 16'h0002, 5'b00100, "lslCarry");
        runOp(OP_LSR, 16'h8001, 16'h0010, 16'h0000, 5'b10100, "lsrFull");
        runOp(OP_LSR, 16'h0006, 16'h0002, 16'h0001, 5'b00100, "lsrTwo");
        runOp(OP_RSL, 16'h8001, 16'h0001, 16'h0003, 5'b00000, "rslOne");
        runOp(OP_RSR, 16'h0001, 16'h0011, 16'h8000, 5'b01000, "rsrMod");
        runOp(OP_AND, 16'h1234, 16'h00FF, 16'h0034, 5'b00000, "andMask");
        runOp(OP_TST, 16'hFF00, 16'h00FF, 16'h0000, 5'b10000, "tstZero");
        runOp(OP_OR,  16'hF000, 16'h000F, 16'hF00F, 5'b01000, "orNeg");
        runOp(OP_NOT, 16'h0000, 16'h5555, 16'hFFFF, 5'b01000, "notZero");
        runOp(OP_MOV, 16'h0000, 16'h0000, 16'h0000, 5'b00000, "movNoFlags");
        runOp(6'h3F,  16'h0001, 16'h0002, 16'h0000, 5'b00001, "illegalOp");

        applyStimulus(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 5'b10010, "mulOvf", 1'b1);
        measureLatency(lat, rdySeen);
        checkOutput("mulLatency", lat, 16);
        checkOutput("mulInReadyLow", {31'h0, rdySeen}, 0);
        waitIdle("mulOvf");
        runOp(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 5'b00000, "mulSmall");
        runOp(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00010, "mulMax");
        runOp(OP_DIV, 16'd100, 16'd7, 16'd14, 5'b00000, "div100by7");
        runOp(OP_MOD, 16'd100, 16'd7, 16'd2, 5'b00000, "mod100by7");

        applyStimulus(OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 5'b01001, "divByZero", 1'b1);
        measureLatency(lat, rdySeen);
        checkOutput("divZeroLatency", lat, 16);
        waitIdle("divByZero");
        runOp(OP_MOD, 16'h1234, 16'h0000, 16'h1234, 5'b00001, "modByZero");

        applyStimulus(OP_DIV, 16'd100, 16'd7, 16'h0000, 5'b00000, "divAbort", 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("abortOutValid", bus.out_valid, 0);
        checkOutput("abortResult", bus.result, 0);
        checkOutput("abortInReadyInReset", bus.in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("abortInReady", bus.in_ready, 1);
        repeat (20) @(posedge clk);
        #2;
        checkOutput("abortNoOutput", bus.out_valid, 0);
        runOp(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 5'b00000, "addAfterReset");

        bus.out_ready = 1'b0;
        applyStimulus(OP_XOR, 16'hF0F0, 16'h0F0F, 16'hFFFF, 5'b01000, "xorHold", 1'b1);
        bus.opcode   = OP_ADD;
        bus.a        = 16'h0001;
        bus.b        = 16'h0001;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("holdValid", bus.out_valid, 1);
            checkOutput("holdResult", bus.result, 16'hFFFF);
            checkOutput("holdFlags", {bus.z, bus.n, bus.c, bus.o, bus.err}, 5'b01000);
            checkOutput("holdInReady", bus.in_ready, 0);
            @(posedge clk);
            #2;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waitIdle("xorHold");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("ignoredInput", bus.out_valid, 0);

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
